// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts exception/interrupt/xRET events, pulses CSR/mstatus/priv writes, then hands a redirect PC to fetch.
// Optional TRAP_VECTORED_INTERRUPT_EN: interrupts vector to base + 4*cause when tvec[1:0] == 1.
module trap_ctrl #(
  parameter int XLEN = 32,
  parameter int NIRQ = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      cur_priv,
  input  logic            ev_valid,
  output logic            ev_ready,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            sret,
  input  logic [XLEN-1:0] ev_pc,
  input  logic [NIRQ-1:0] irq_pending,
  input  logic            mstatus_mie,
  input  logic            mstatus_sie,
  input  logic            mstatus_mpie,
  input  logic            mstatus_spie,
  input  logic [1:0]      mstatus_mpp,
  input  logic            mstatus_spp,
  input  logic [XLEN-1:0] medeleg,
  input  logic [NIRQ-1:0] mideleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  output logic            flush,
  output logic            trap_w_en,
  output logic            trap_to_s,
  output logic [XLEN-1:0] epc_val,
  output logic [XLEN-1:0] tval_val,
  output logic [XLEN-1:0] cause_val,
  output logic            mstatus_w_en,
  output logic            new_mie,
  output logic            new_sie,
  output logic            new_mpie,
  output logic            new_spie,
  output logic [1:0]      new_mpp,
  output logic            new_spp,
  output logic            priv_w_en,
  output logic [1:0]      priv_w_val,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;
  state_t state_q, state_d;

  logic            trap_q, trap_d;
  logic            to_s_q, to_s_d;
  logic [XLEN-1:0] epc_q, epc_d, tval_q, tval_d, cause_q, cause_d, rpc_q, rpc_d;
  logic [6:0]      mst_q, mst_d;   // {mie, sie, mpie, spie, mpp[1:0], spp}
  logic [1:0]      priv_q, priv_d;

  // Fixed architectural priority first, then lowest index.
  function automatic int irq_rank(input int i);
    case (i)
      11:      irq_rank = 0;
      3:       irq_rank = 1;
      7:       irq_rank = 2;
      9:       irq_rank = 3;
      1:       irq_rank = 4;
      5:       irq_rank = 5;
      default: irq_rank = 6 + i;
    endcase
  endfunction

  logic [NIRQ-1:0] irq_take;
  always_comb begin
    irq_take = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (irq_pending[i]) begin
        if (mideleg[i] && cur_priv != 2'd3)
          irq_take[i] = (cur_priv == 2'd0) || (cur_priv == 2'd1 && mstatus_sie);
        else
          irq_take[i] = (cur_priv != 2'd3) || mstatus_mie;
      end
    end
  end

  logic          irq_found;
  logic [IW-1:0] irq_idx;
  always_comb begin
    int best;
    best      = NIRQ + 6;
    irq_found = 1'b0;
    irq_idx   = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (irq_take[i] && irq_rank(i) < best) begin
        best      = irq_rank(i);
        irq_found = 1'b1;
        irq_idx   = IW'(i);
      end
    end
  end

  logic is_exc, is_mret, is_sret, is_irq, is_trap, tgt_s, accept;
  assign is_exc  = exc_valid;
  assign is_mret = !exc_valid && mret;
  assign is_sret = !exc_valid && !mret && sret;
  assign is_irq  = !exc_valid && !mret && !sret && irq_found;
  assign is_trap = is_exc || is_irq;
  assign tgt_s   = is_trap && (cur_priv != 2'd3) &&
                   (is_exc ? medeleg[exc_cause] : mideleg[irq_idx]);
  assign accept  = ev_valid && (state_q == IDLE) && (is_trap || is_mret || is_sret);

  logic [XLEN-1:0] tvec_sel, tvec_base, trap_pc;
  assign tvec_sel  = tgt_s ? stvec : mtvec;
  assign tvec_base = {tvec_sel[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_INTERRUPT_EN
  assign trap_pc = tvec_base +
                   ((is_irq && tvec_sel[1:0] == 2'b01) ? (XLEN'(irq_idx) << 2) : '0);
`else
  logic unused_tvec_mode;
  assign unused_tvec_mode = ^tvec_sel[1:0];
  assign trap_pc = tvec_base;
`endif

  always_comb begin
    logic n_mie, n_sie, n_mpie, n_spie, n_spp;
    logic [1:0] n_mpp;
    state_d = state_q;
    trap_d  = trap_q;
    to_s_d  = to_s_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    cause_d = cause_q;
    rpc_d   = rpc_q;
    mst_d   = mst_q;
    priv_d  = priv_q;
    n_mie   = mstatus_mie;
    n_sie   = mstatus_sie;
    n_mpie  = mstatus_mpie;
    n_spie  = mstatus_spie;
    n_mpp   = mstatus_mpp;
    n_spp   = mstatus_spp;
    case (state_q)
      IDLE: if (accept) begin
        state_d = COMMIT;
        trap_d  = is_trap;
        to_s_d  = tgt_s;
        epc_d   = is_trap ? ev_pc : '0;
        tval_d  = is_exc ? exc_tval : '0;
        cause_d = is_exc ? {{(XLEN-5){1'b0}}, exc_cause} :
                  is_irq ? {1'b1, {(XLEN-1-IW){1'b0}}, irq_idx} : '0;
        if (is_trap && tgt_s) begin
          n_spie = mstatus_sie; n_sie = 1'b0; n_spp = cur_priv[0];
          priv_d = 2'd1; rpc_d = trap_pc;
        end else if (is_trap) begin
          n_mpie = mstatus_mie; n_mie = 1'b0; n_mpp = cur_priv;
          priv_d = 2'd3; rpc_d = trap_pc;
        end else if (is_mret) begin
          n_mie = mstatus_mpie; n_mpie = 1'b1; n_mpp = 2'd0;
          priv_d = mstatus_mpp; rpc_d = mepc;
        end else begin
          n_sie = mstatus_spie; n_spie = 1'b1; n_spp = 1'b0;
          priv_d = {1'b0, mstatus_spp}; rpc_d = sepc;
        end
        mst_d = {n_mie, n_sie, n_mpie, n_spie, n_mpp, n_spp};
      end
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      trap_q  <= 1'b0;
      to_s_q  <= 1'b0;
      epc_q   <= '0;
      tval_q  <= '0;
      cause_q <= '0;
      rpc_q   <= '0;
      mst_q   <= '0;
      priv_q  <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      to_s_q  <= to_s_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      cause_q <= cause_d;
      rpc_q   <= rpc_d;
      mst_q   <= mst_d;
      priv_q  <= priv_d;
    end
  end

  // Everything is gated by state so nothing leaks outside its phase.
  logic commit;
  assign commit         = (state_q == COMMIT);
  assign ev_ready       = (state_q == IDLE);
  assign flush          = commit;
  assign priv_w_en      = commit;
  assign mstatus_w_en   = commit;
  assign trap_w_en      = commit && trap_q;
  assign trap_to_s      = commit && to_s_q;
  assign epc_val        = commit ? epc_q   : '0;
  assign tval_val       = commit ? tval_q  : '0;
  assign cause_val      = commit ? cause_q : '0;
  assign priv_w_val     = commit ? priv_q  : '0;
  assign {new_mie, new_sie, new_mpie, new_spie, new_mpp, new_spp} = commit ? mst_q : '0;
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_valid ? rpc_q : '0;
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer directly upstream of the privilege-mode register. It accepts exception, interrupt and xRET events from the pipeline commit point and selects M or S handling via medeleg/mideleg.
- It issues one-cycle CSR and mstatus update pulses plus the priv write, then hands a redirect PC to fetch over a valid/ready handshake.
- It is the only writer of the privilege mode.

Parameters:
- XLEN, 32, data/address width.
- NIRQ, 16, width of interrupt pending/enable vectors; cause codes 0..NIRQ-1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cur_priv  in  2  current mode from privilege register (0=U, 1=S, 3=M)
- ev_valid  in  1  pipeline has a committing event
- ev_ready  out  1  high only in IDLE; event accepted when ev_valid&&ev_ready
- exc_valid  in  1  event is a synchronous exception
- exc_cause  in  5  exception code
- exc_tval  in  XLEN  trap value
- mret  in  1  event is MRET
- sret  in  1  event is SRET
- ev_pc  in  XLEN  PC of the trapping / interrupted instruction
- irq_pending  in  NIRQ  mip & mie, already masked
- mstatus_mie, mstatus_sie, mstatus_mpie, mstatus_spie  in  1 each
- mstatus_mpp  in  2
- mstatus_spp  in  1
- medeleg, mideleg  in  XLEN / NIRQ  delegation masks
- mtvec, stvec, mepc, sepc  in  XLEN each
- flush  out  1  kill younger pipeline state
- trap_w_en  out  1  write xepc/xcause/xtval
- trap_to_s  out  1  target of trap_w_en is the S-level CSR set
- epc_val, tval_val  out  XLEN
- cause_val  out  XLEN  MSB = interrupt flag
- mstatus_w_en  out  1  load the new_* mstatus fields
- new_mie, new_sie, new_mpie, new_spie  out  1 each
- new_mpp  out  2
- new_spp  out  1
- priv_w_en  out  1
- priv_w_val  out  2
- redirect_valid  out  1
- redirect_pc  out  XLEN
- redirect_ready  in  1

Behaviour:
- FSM states: IDLE, COMMIT, REDIRECT. Reset forces IDLE; every output is 0 except ev_ready=1.
- IDLE: accept on ev_valid. Event priority is exc_valid > mret > sret > interrupt.
- An interrupt is taken only when ev_valid is high and no other event is flagged; it always uses ev_pc.
- Interrupt selection order by cause: 11, 3, 7, 9, 1, 5, then the lowest remaining index.
- Interrupt enable rule:
  - If the mideleg bit is set and cur_priv != M, the target is S. It is taken if cur_priv == U, or if cur_priv == S and SIE == 1.
  - Otherwise the target is M. It is taken if cur_priv != M or MIE == 1.
- If no event qualifies, stay in IDLE and do not accept.
- Exception target: S when medeleg[cause] == 1 and cur_priv != M; otherwise M.
- All selection results are registered on acceptance. Event inputs are don't-care afterwards.
- COMMIT lasts exactly 1 cycle (acceptance cycle + 1). flush=1, priv_w_en=1, mstatus_w_en=1.
- Trap to M:
  - trap_w_en=1; epc=ev_pc; cause as selected; tval = exc_tval for exceptions, 0 for interrupts.
  - new_mpie=MIE, new_mie=0, new_mpp=cur_priv, priv_w_val=3.
  - All other new_* fields echo their inputs.
- Trap to S:
  - trap_to_s=1.
  - new_spie=SIE, new_sie=0, new_spp=cur_priv[0], priv_w_val=1.
- MRET:
  - trap_w_en=0; new_mie=MPIE, new_mpie=1, new_mpp=0, priv_w_val=MPP.
  - Redirect target is mepc.
- SRET:
  - new_sie=SPIE, new_spie=1, new_spp=0, priv_w_val={1'b0, SPP}.
  - Redirect target is sepc.
- Trap redirect target: mtvec or stvec with bits [1:0] cleared.
- REDIRECT: redirect_valid held high and redirect_pc held stable until redirect_ready. Return to IDLE on the same edge as the handshake.
- ev_ready=1 again in the cycle after the handshake. Minimum accept-to-accept spacing is 3 cycles.
- Asserting reset in COMMIT or REDIRECT aborts immediately. No partial pulse is observed after reset deasserts.
- All write-enable outputs are single-cycle pulses and are never asserted outside COMMIT.

Optional Feature:
- Macro: TRAP_VECTORED_INTERRUPT_EN.
- Defined: for an interrupt trap whose target tvec[1:0] == 1, redirect_pc = {tvec[XLEN-1:2], 2'b00} + 4*cause. Exceptions still use the base address.
- Undefined: tvec[1:0] is ignored; all traps redirect to the base address.

Test Plan:
- Reset: reset=1 mid-REDIRECT -> next cycle ev_ready=1, redirect_valid=0, all write enables 0.
- ecall from U (cause 8, medeleg bit 8 = 0), ev_pc=0x100, mtvec=0x8000_0000, MIE=1:
  - Next cycle: trap_w_en=1, cause_val=8, epc_val=0x100, new_mpp=0, new_mie=0, new_mpie=1, priv_w_val=3.
  - Then: redirect_pc=0x8000_0000.
- Same ecall with medeleg[8]=1 from U, stvec=0x4000 -> trap_to_s=1, priv_w_val=1, new_spp=0, redirect_pc=0x4000.
- MRET with mstatus_mpp=1, MPIE=1, mepc=0x2000 -> new_mie=1, new_mpp=0, priv_w_val=1, redirect_pc=0x2000, trap_w_en=0.
- irq_pending bits 7 and 11 set, cur_priv=M, MIE=1 -> cause_val=0x8000_000B.
  - With macro defined and mtvec=0x1001: redirect_pc=0x102C.
  - Without the macro: redirect_pc=0x1000.
- redirect_ready held low for 5 cycles -> redirect_valid and redirect_pc stable, ev_ready=0 throughout. A concurrent exc_valid is not accepted until the cycle after the handshake.
